// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter:
// ownership state encoding and default bus widths matching the processor.
package mem_arbiter_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 8;
  localparam int MAX_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e own_state(input logic master);
    return master ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side handshakes plus the memory port of the arbiter, bundled so the
// arbiter (slave) and the masters/memory environment (master) share one view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              m0_req;
  logic              m0_lock;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_grant;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_lock;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_grant;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    input  mem_q,
    output m0_grant, m0_rvalid, m1_grant, m1_rvalid,
    output rdata, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output m0_req, m0_lock, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_wr, m1_addr, m1_wdata,
    output mem_q,
    input  m0_grant, m0_rvalid, m1_grant, m1_rvalid,
    input  rdata, mem_addr, mem_wr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared single-port data memory:
// registered grants, bounded optional lock, read-valid routed to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  mem_arbiter_if.slave bus
);

  // state   | meaning
  // ST_IDLE | no owner; memory port follows master 0, never written
  // ST_OWN0 | master 0 owns the memory port
  // ST_OWN1 | master 1 owns the memory port

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              rvalid0_q, rvalid1_q;
  logic              accept0, accept1;
  logic              own_req, own_lock, oth_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign accept0 = bus.m0_req & (state_q == ST_OWN0);
  assign accept1 = bus.m1_req & (state_q == ST_OWN1);

  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    case (state_q)
      ST_OWN0: begin
        own_req  = bus.m0_req;
        own_lock = bus.m0_lock;
        oth_req  = bus.m1_req;
      end
      ST_OWN1: begin
        own_req  = bus.m1_req;
        own_lock = bus.m1_lock;
        oth_req  = bus.m0_req;
      end
      default: ;
    endcase
  end

  // lock_cnt excludes the accept happening this cycle, so comparing against
  // MAX_LOCK-1 makes this accept the last one before a forced hand-over.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_req & bus.m1_req) state_d = own_state(~last_q);
        else if (bus.m0_req)         state_d = ST_OWN0;
        else if (bus.m1_req)         state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (own_req & own_lock & (~oth_req | (lock_cnt_q < CNT_LAST)))
          state_d = state_q;
        else if (oth_req)
          state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
        else if (own_req)
          state_d = state_q;
        else
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if ((state_d != state_q) | ~own_req)
      lock_cnt_d = '0;
    else if ((accept0 | accept1) & (lock_cnt_q != CNT_SAT))
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
  end

  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == ST_OWN0)      last_d = 1'b0;
      else if (state_d == ST_OWN1) last_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= accept0 & ~bus.m0_wr;
      rvalid1_q  <= accept1 & ~bus.m1_wr;
    end
  end

  // Master 0 drives the memory port whenever master 1 is not the owner.
  always_comb begin
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    if (state_q == ST_OWN1) begin
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
    end
  end

  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_wr    = (accept0 & bus.m0_wr) | (accept1 & bus.m1_wr);

  assign bus.m0_grant  = (state_q == ST_OWN0);
  assign bus.m1_grant  = (state_q == ST_OWN1);
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.rdata     = bus.mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level ownership model; a behavioural RAM sits on the port.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int ML = 4;

  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_LOCK(ML)) dut (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .bus     (bus)
  );

  logic [DW-1:0] mem [256];

  always @(posedge CLOCK_50) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic idle_in();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_in();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.m0_req = 1; bus.m0_wr = 1; bus.m0_addr = 8'h10; bus.m0_wdata = 16'hBEEF;
    #1;
    n_cmp++; if (bus.m0_grant !== 1'b0) begin n_bad++; $display("FAIL reset_g0: got %b want 0", bus.m0_grant); end
    n_cmp++; if (bus.m1_grant !== 1'b0) begin n_bad++; $display("FAIL reset_g1: got %b want 0", bus.m1_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_memwr: got %b want 0", bus.mem_wr); end
    n_cmp++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); end
    tick(); #1;
    n_cmp++; if (bus.m0_grant !== 1'b1) begin n_bad++; $display("FAIL preload_g0: got %b want 1", bus.m0_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b1) begin n_bad++; $display("FAIL preload_memwr: got %b want 1", bus.mem_wr); end
    n_cmp++; if (bus.mem_addr !== 8'h10 || bus.mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL preload_port: got %h/%h want 10/beef", bus.mem_addr, bus.mem_wdata); end
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 8'h10;
    #1;
    n_cmp++; if (bus.m0_grant !== 1'b0) begin n_bad++; $display("FAIL single_c0_g0: got %b want 0", bus.m0_grant); end
    tick(); #1;
    n_cmp++; if (bus.m0_grant !== 1'b1) begin n_bad++; $display("FAIL single_c1_g0: got %b want 1", bus.m0_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b0 || bus.mem_addr !== 8'h10) begin n_bad++; $display("FAIL single_c1_port: got wr=%b addr=%h want 0/10", bus.mem_wr, bus.mem_addr); end
    tick();
    idle_in();
    #1;
    n_cmp++; if (bus.m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL single_c2_rv0: got %b want 1", bus.m0_rvalid); end
    n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_bad++; $display("FAIL single_c2_rdata: got %h want beef", bus.rdata); end
    n_cmp++; if (bus.m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL single_c2_rv1: got %b want 0", bus.m1_rvalid); end
    tick(); #1;
    n_cmp++; if (bus.m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL single_c3_rv0: got %b want 0", bus.m0_rvalid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 8'h20;
    bus.m1_req = 1; bus.m1_addr = 8'h30;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.m0_grant !== (i % 2 == 0) || bus.m1_grant !== (i % 2 == 1)) begin
        n_bad++; $display("FAIL alt_grant[%0d]: got %b%b want %b%b", i, bus.m0_grant, bus.m1_grant, (i % 2 == 0), (i % 2 == 1));
      end
      n_cmp++; if (bus.mem_addr !== ((i % 2 == 0) ? 8'h20 : 8'h30)) begin
        n_bad++; $display("FAIL alt_addr[%0d]: got %h want %h", i, bus.mem_addr, (i % 2 == 0) ? 8'h20 : 8'h30);
      end
      tick();
    end
    idle_in();
    tick();
  endtask

  task automatic test_locked_burst();
    int exp_g [10];
    int idx0;
    bit m1_done;
    exp_g = '{-1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    idx0 = 0;
    m1_done = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.m0_req = (idx0 < 8); bus.m0_lock = 1; bus.m0_wr = 1;
      bus.m0_addr = 8'(idx0); bus.m0_wdata = 16'hA000 | 16'(idx0);
      bus.m1_req = !m1_done; bus.m1_lock = 0; bus.m1_wr = 1;
      bus.m1_addr = 8'h40; bus.m1_wdata = 16'h5555;
      #1;
      n_cmp++; if (bus.m0_grant !== (exp_g[c] == 0) || bus.m1_grant !== (exp_g[c] == 1)) begin
        n_bad++; $display("FAIL burst_grant[%0d]: got %b%b want %b%b", c, bus.m0_grant, bus.m1_grant, (exp_g[c] == 0), (exp_g[c] == 1));
      end
      if (bus.m0_grant && bus.m0_req) idx0++;
      if (bus.m1_grant && bus.m1_req) m1_done = 1;
      tick();
    end
    idle_in();
    tick();
    for (int a = 0; a < 8; a++) begin
      n_cmp++; if (mem[a] !== (16'hA000 | 16'(a))) begin n_bad++; $display("FAIL burst_mem[%0d]: got %h want %h", a, mem[a], 16'hA000 | 16'(a)); end
    end
    n_cmp++; if (mem[8'h40] !== 16'h5555) begin n_bad++; $display("FAIL burst_mem_m1: got %h want 5555", mem[8'h40]); end
  endtask

  task automatic test_lock_idle_other();
    do_reset();
    bus.m0_req = 1; bus.m0_lock = 1; bus.m0_wr = 0; bus.m0_addr = 8'h03;
    tick();
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_cmp++; if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) begin
        n_bad++; $display("FAIL lockidle_grant[%0d]: got %b%b want 10", c, bus.m0_grant, bus.m1_grant);
      end
      tick();
    end
    idle_in();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_wr = 0; bus.m1_addr = 8'h40;
    tick(); #1;
    n_cmp++; if (bus.m1_grant !== 1'b1) begin n_bad++; $display("FAIL midrst_c1_g1: got %b want 1", bus.m1_grant); end
    tick();
    Reset = 1'b1;
    #1;
    n_cmp++; if (bus.m1_rvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_c2_rv1: got %b want 1", bus.m1_rvalid); end
    tick();
    Reset = 1'b0;
    bus.m1_wr = 1; bus.m1_wdata = 16'h0BAD;
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 8'h05;
    #1;
    n_cmp++; if (bus.m0_grant !== 1'b0 || bus.m1_grant !== 1'b0) begin n_bad++; $display("FAIL midrst_c3_grant: got %b%b want 00", bus.m0_grant, bus.m1_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL midrst_c3_memwr: got %b want 0", bus.mem_wr); end
    n_cmp++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_c3_rvalid: got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); end
    tick(); #1;
    n_cmp++; if (bus.m0_grant !== 1'b1 || bus.m1_grant !== 1'b0) begin n_bad++; $display("FAIL midrst_c4_grant: got %b%b want 10", bus.m0_grant, bus.m1_grant); end
    idle_in();
    tick();
  endtask

  task automatic test_drop_req();
    do_reset();
    bus.m0_req = 1; bus.m0_wr = 0; bus.m0_addr = 8'h01;
    tick();
    tick();
    bus.m0_req = 0;
    bus.m1_req = 1; bus.m1_wr = 1; bus.m1_addr = 8'h41; bus.m1_wdata = 16'h1234;
    #1;
    n_cmp++; if (bus.m0_grant !== 1'b1) begin n_bad++; $display("FAIL drop_c2_g0: got %b want 1", bus.m0_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_bad++; $display("FAIL drop_c2_memwr: got %b want 0", bus.mem_wr); end
    tick(); #1;
    n_cmp++; if (bus.m1_grant !== 1'b1 || bus.m0_grant !== 1'b0) begin n_bad++; $display("FAIL drop_c3_grant: got %b%b want 01", bus.m0_grant, bus.m1_grant); end
    n_cmp++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 8'h41) begin n_bad++; $display("FAIL drop_c3_port: got wr=%b addr=%h want 1/41", bus.mem_wr, bus.mem_addr); end
    idle_in();
    tick();
  endtask

  // Reference: owner index (-1 = none), who was granted last, and how many
  // accesses the current owner has had in a row.
  task automatic test_random(input int n_cycles);
    int own, mlast, run, served, nxt, oth;
    bit r_req [2], r_lock [2], r_wr [2], fresh [2], acc [2];
    bit pend [2], pknown [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_wdata [2], pdata [2];
    logic [DW-1:0] rmem [256];
    bit known [256];
    bit rst_now, ewr;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
    do_reset();
    own = -1; mlast = 1; run = 0;
    for (int m = 0; m < 2; m++) begin
      fresh[m] = 1; pend[m] = 0; pknown[m] = 0; r_req[m] = 0;
    end
    for (int a = 0; a < 256; a++) known[a] = 0;
    for (int c = 0; c < n_cycles; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (fresh[m]) begin
          r_req[m]   = ($urandom_range(0, 99) < 60);
          r_lock[m]  = ($urandom_range(0, 99) < 70);
          r_wr[m]    = ($urandom_range(0, 1) == 1);
          r_addr[m]  = AW'($urandom_range(0, 31));
          r_wdata[m] = DW'($urandom);
        end
      end
      rst_now = ($urandom_range(0, 99) < 2);
      Reset = rst_now;
      bus.m0_req = r_req[0]; bus.m0_lock = r_lock[0]; bus.m0_wr = r_wr[0];
      bus.m0_addr = r_addr[0]; bus.m0_wdata = r_wdata[0];
      bus.m1_req = r_req[1]; bus.m1_lock = r_lock[1]; bus.m1_wr = r_wr[1];
      bus.m1_addr = r_addr[1]; bus.m1_wdata = r_wdata[1];
      #1;
      acc[0] = r_req[0] && (own == 0);
      acc[1] = r_req[1] && (own == 1);
      ewr    = (acc[0] && r_wr[0]) || (acc[1] && r_wr[1]);
      eaddr  = (own == 1) ? r_addr[1] : r_addr[0];
      ewdata = (own == 1) ? r_wdata[1] : r_wdata[0];
      n_cmp++; if (bus.m0_grant !== (own == 0) || bus.m1_grant !== (own == 1)) begin
        n_bad++; $display("FAIL rnd_grant[%0d]: got %b%b want owner %0d", c, bus.m0_grant, bus.m1_grant, own);
      end
      n_cmp++; if (bus.mem_wr !== ewr) begin n_bad++; $display("FAIL rnd_memwr[%0d]: got %b want %b", c, bus.mem_wr, ewr); end
      n_cmp++; if (bus.mem_addr !== eaddr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, bus.mem_addr, eaddr); end
      if (ewr) begin
        n_cmp++; if (bus.mem_wdata !== ewdata) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, bus.mem_wdata, ewdata); end
      end
      n_cmp++; if (bus.m0_rvalid !== pend[0] || bus.m1_rvalid !== pend[1]) begin
        n_bad++; $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", c, bus.m0_rvalid, bus.m1_rvalid, pend[0], pend[1]);
      end
      for (int m = 0; m < 2; m++) begin
        if (pend[m] && pknown[m]) begin
          n_cmp++; if (bus.rdata !== pdata[m]) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, bus.rdata, pdata[m]); end
        end
      end
      for (int m = 0; m < 2; m++) begin
        pend[m] = acc[m] && !r_wr[m] && !rst_now;
        if (acc[m] && !r_wr[m]) begin
          pdata[m]  = rmem[r_addr[m]];
          pknown[m] = known[r_addr[m]];
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (acc[m] && r_wr[m]) begin
          rmem[r_addr[m]]  = r_wdata[m];
          known[r_addr[m]] = 1;
        end
        fresh[m] = !r_req[m] || acc[m];
      end
      if (own < 0) begin
        if (r_req[0] && r_req[1]) nxt = (mlast == 1) ? 0 : 1;
        else if (r_req[0])        nxt = 0;
        else if (r_req[1])        nxt = 1;
        else                      nxt = -1;
        served = 0;
      end else begin
        oth = 1 - own;
        served = r_req[own] ? run + 1 : 0;
        if (r_req[own] && r_lock[own] && (!r_req[oth] || served < ML)) nxt = own;
        else if (r_req[oth]) nxt = oth;
        else if (r_req[own]) nxt = own;
        else                 nxt = -1;
      end
      if (nxt != own) begin
        run = 0;
        if (nxt >= 0) mlast = nxt;
      end else begin
        run = served;
      end
      own = nxt;
      if (rst_now) begin
        own = -1; mlast = 1; run = 0;
      end
      tick();
    end
    Reset = 1'b0;
    idle_in();
    tick();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_locked_burst();
    test_lock_idle_other();
    test_reset_mid_burst();
    test_drop_req();
    test_random(1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
